pool_stream_framer: RTL
=======================

# pool_stream_framer

Upstream feeder for the max-pool stage. It takes a raw, unpadded feature-map stream from the DMA and emits the framed stream the pooling stage consumes:
- one stride/config header word, closed with TLAST;
- then every image row with PAD zero words on the left and right, with TLAST on the final word of the frame.

It runs counter-driven framing and an AXI-Stream handshake on one clock, with a registered output.

## Interface
Parameters:
- IMG_W, 448, pixels per unpadded row
- IMG_H, 448, rows per frame
- PAD, 1, zero words inserted at each row edge
- DATA_W, 32, word width (float32 pixels)

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - S_AXIS_ACLK  in  1  clock for everything
  - S_AXIS_ARESET  in  1  synchronous, active-high reset
- Configuration:
  - cfg_stride  in  32  pool stride, sampled on IDLE→HDR
- Input stream:
  - S_AXIS_TDATA  in  DATA_W  raw pixel
  - S_AXIS_TKEEP  in  2  forwarded only when ==3
  - S_AXIS_TLAST  in  1  checked, not used for framing
  - S_AXIS_TVALID  in  1  upstream beat valid
  - S_AXIS_TREADY  out  1  framer accepts pixel
- Output stream:
  - M_AXIS_TDATA  out  DATA_W  header, pixel or zero
  - M_AXIS_TKEEP  out  2  constant 3
  - M_AXIS_TLAST  out  1  on header word and on final frame word
  - M_AXIS_TVALID  out  1  output register full
  - M_AXIS_TREADY  in  1  downstream accepts
- Status:
  - frame_done  out  1  one-cycle pulse when the last word handshakes
  - err_tlast  out  1  sticky input-TLAST mismatch flag

## Operation
- **Frame length:** 1 + IMG_H*(IMG_W+2*PAD) output words.
- **Output register:** a single entry.
  - It loads when its load condition is true and it is empty or draining (M_AXIS_TREADY high).
  - An output beat transfers when TVALID && TREADY.
- **FSM states:** IDLE, HDR, PADL, DATA, PADR.
- **IDLE:**
  - S_AXIS_TREADY=0.
  - On S_AXIS_TVALID=1, latch the stride (cfg_stride, or 1 if cfg_stride==0) and go to HDR. The pending pixel is not consumed.
- **HDR:** load {stride, TLAST=1} and go to PADL.
- **PADL:** load PAD zero words (TLAST=0), counted by col_cnt, then go to DATA.
- **DATA:**
  - S_AXIS_TREADY = !M_AXIS_TVALID || M_AXIS_TREADY.
  - Each accepted beat with TKEEP==3 loads TDATA and advances col_cnt.
  - Accepted beats with TKEEP!=3 are dropped and not counted.
  - After IMG_W counted pixels, go to PADR.
- **PADR:**
  - Load PAD zero words.
  - The final zero of the final row (row_cnt==IMG_H-1) carries TLAST=1.
  - At row end: if it is the last row, go to IDLE once that word is loaded; otherwise increment row_cnt and go to PADL.
- **Counters:**
  - col_cnt spans 0..IMG_W+2*PAD-1 and wraps to 0 at row end.
  - row_cnt spans 0..IMG_H-1 and clears at frame end.
  - Widths are $clog2 of the range plus 1.
- **err_tlast** sets when either:
  - an input TLAST is accepted on any counted pixel other than pixel IMG_W*IMG_H-1;
  - or that last pixel arrives with TLAST=0.
  
  It clears only on reset. Framing continues regardless.
- **frame_done:** pulses on the cycle the TLAST=1 frame-final word handshakes. The header's TLAST does not pulse it.

## Timing
- **Reset values:** M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0, S_AXIS_TREADY=0, frame_done=0, err_tlast=0, state=IDLE, counters=0. M_AXIS_TKEEP=3 always.
- **Latency:** an accepted pixel appears on M_AXIS_TDATA the next cycle.
- **Header timing:** the header appears 2 cycles after the S_AXIS_TVALID that leaves IDLE.
- **Throughput:** one word per cycle with TREADY held high. No bubbles between pad and data words when input is valid.
- **Backpressure:** while M_AXIS_TVALID && !M_AXIS_TREADY, TDATA and TLAST hold stable and S_AXIS_TREADY=0.
- **Input stall:** in DATA with no input, M_AXIS_TVALID drops after the current word drains; pads are never inserted mid-row.
- **Back-to-back frames:** IDLE is re-entered on the cycle the last word loads. A new frame's header can load as soon as the register drains, with no idle cycle required beyond the IDLE evaluation.
- **Reset mid-frame:** the in-flight output word is discarded and the FSM returns to IDLE. The next frame starts with a fresh header.

## Structure
- **Package pool_pkg:**
  - state enum (IDLE/HDR/PADL/DATA/PADR);
  - DATA_W default;
  - TKEEP_ALL=2'b11 constant.
- **Sub-module axis_out_reg:**
  - one-entry AXI-Stream register (data, last, valid, ready);
  - load/drain logic;
  - instantiated once.
- **Top level:** FSM, counters, stride latch, TLAST checker.

## Test plan
All scenarios use IMG_W=4, IMG_H=3, PAD=1, giving a frame of 19 words.
- **Basic frame:**
  - Stimulus: cfg_stride=2; 12 pixels 1..12 with TLAST on 12; TREADY held 1.
  - Required output: 2(L), then 0,1,2,3,4,0, 0,5..8,0, 0,9..12,0(L).
  - err_tlast=0; frame_done pulses once, on the final handshake.
- **Random backpressure:** M_AXIS_TREADY random 50% → identical word sequence, no duplicates or drops, TDATA stable while stalled.
- **Input gaps and TKEEP:** random S_AXIS_TVALID gaps plus one TKEEP=1 beat mid-row → that beat is absent from the output, and the row is still 4 pixels.
- **TLAST errors and stride clamp:**
  - TLAST on pixel 7 → err_tlast=1 from the next cycle; output framing unchanged.
  - Second frame with cfg_stride=0 → header word = 1.
- **Reset mid-frame:** reset asserted after 8 output words → all outputs at reset values next cycle; the following frame starts with its header and completes correctly.
- **Back-to-back frames:** two frames with continuous input → 38 words, two frame_done pulses, no extra idle beats beyond the IDLE evaluation cycle.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared types and constants for the max-pool stream framer.
package pool_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      PADL,
      DATA,
      PADR
   } state_e;

   localparam int         POOL_DATA_W = 32;
   localparam logic [1:0] TKEEP_ALL   = 2'b11;

endpackage

// File: rtl/axis_out_reg.sv
// One-entry AXI-Stream output register with a frame-final sideband bit.
module axis_out_reg
   import pool_pkg::*;
#(
   parameter int DATA_W = POOL_DATA_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              last_i,
   input  logic              fin_i,
   input  logic              ready_i,
   output logic [DATA_W-1:0] data_o,
   output logic              last_o,
   output logic              fin_o,
   output logic              valid_o,
   output logic              can_load_o
);

   logic [DATA_W-1:0] data_q;
   logic              last_q;
   logic              fin_q;
   logic              valid_q;

   assign can_load_o = !valid_q || ready_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_q  <= '0;
         last_q  <= 1'b0;
         fin_q   <= 1'b0;
         valid_q <= 1'b0;
      end else if (load_i && can_load_o) begin
         data_q  <= data_i;
         last_q  <= last_i;
         fin_q   <= fin_i;
         valid_q <= 1'b1;
      end else if (ready_i) begin
         valid_q <= 1'b0;
      end
   end

   assign data_o  = data_q;
   assign last_o  = last_q;
   assign fin_o   = fin_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/pool_stream_framer.sv
// Frames a raw feature-map stream: stride header, then rows padded with zeros.
module pool_stream_framer
   import pool_pkg::*;
#(
   parameter int IMG_W  = 448,
   parameter int IMG_H  = 448,
   parameter int PAD    = 1,
   parameter int DATA_W = POOL_DATA_W
) (
   input  logic              S_AXIS_ACLK,
   input  logic              S_AXIS_ARESET,
   input  logic [31:0]       cfg_stride,
   input  logic [DATA_W-1:0] S_AXIS_TDATA,
   input  logic [1:0]        S_AXIS_TKEEP,
   input  logic              S_AXIS_TLAST,
   input  logic              S_AXIS_TVALID,
   output logic              S_AXIS_TREADY,
   output logic [DATA_W-1:0] M_AXIS_TDATA,
   output logic [1:0]        M_AXIS_TKEEP,
   output logic              M_AXIS_TLAST,
   output logic              M_AXIS_TVALID,
   input  logic              M_AXIS_TREADY,
   output logic              frame_done,
   output logic              err_tlast
);

   localparam int ROW_LEN = IMG_W + 2 * PAD;
   localparam int COL_W   = $clog2(ROW_LEN) + 1;
   localparam int ROW_W   = $clog2(IMG_H) + 1;

   localparam logic [COL_W-1:0] C_PADL_END = COL_W'(PAD - 1);
   localparam logic [COL_W-1:0] C_DATA_END = COL_W'(PAD + IMG_W - 1);
   localparam logic [COL_W-1:0] C_ROW_END  = COL_W'(ROW_LEN - 1);
   localparam logic [ROW_W-1:0] R_LAST     = ROW_W'(IMG_H - 1);

   state_e            state_q, state_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [31:0]       stride_q, stride_d;
   logic              err_q, err_d;

   logic              load;
   logic [DATA_W-1:0] ld_data;
   logic              ld_last;
   logic              ld_fin;
   logic              s_ready;
   logic              can_load;
   logic              fin;
   logic              last_pix;

   assign last_pix = (row_q == R_LAST) && (col_q == C_DATA_END);

   always_ff @(posedge S_AXIS_ACLK) begin
      if (S_AXIS_ARESET) begin
         state_q  <= IDLE;
         col_q    <= '0;
         row_q    <= '0;
         stride_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         col_q    <= col_d;
         row_q    <= row_d;
         stride_q <= stride_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      col_d    = col_q;
      row_d    = row_q;
      stride_d = stride_q;
      err_d    = err_q;
      load     = 1'b0;
      ld_data  = '0;
      ld_last  = 1'b0;
      ld_fin   = 1'b0;
      s_ready  = 1'b0;
      unique case (state_q)
         IDLE: begin
            // The waking beat stays pending; it is consumed in DATA.
            if (S_AXIS_TVALID) begin
               stride_d = (cfg_stride == '0) ? 32'd1 : cfg_stride;
               state_d  = HDR;
            end
         end
         HDR: begin
            if (can_load) begin
               load    = 1'b1;
               ld_data = DATA_W'(stride_q);
               ld_last = 1'b1;
               state_d = PADL;
            end
         end
         PADL: begin
            if (can_load) begin
               load  = 1'b1;
               col_d = col_q + 1'b1;
               if (col_q == C_PADL_END) state_d = DATA;
            end
         end
         DATA: begin
            s_ready = can_load;
            if (S_AXIS_TVALID && can_load &&
                S_AXIS_TKEEP == TKEEP_ALL) begin
               load    = 1'b1;
               ld_data = S_AXIS_TDATA;
               col_d   = col_q + 1'b1;
               if (S_AXIS_TLAST != last_pix) err_d = 1'b1;
               if (col_q == C_DATA_END) state_d = PADR;
            end
         end
         PADR: begin
            if (can_load) begin
               load = 1'b1;
               if (col_q == C_ROW_END) begin
                  col_d = '0;
                  if (row_q == R_LAST) begin
                     ld_last = 1'b1;
                     ld_fin  = 1'b1;
                     row_d   = '0;
                     state_d = IDLE;
                  end else begin
                     row_d   = row_q + 1'b1;
                     state_d = PADL;
                  end
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   axis_out_reg #(
      .DATA_W(DATA_W)
   ) u_out (
      .clk_i     (S_AXIS_ACLK),
      .rst_i     (S_AXIS_ARESET),
      .load_i    (load),
      .data_i    (ld_data),
      .last_i    (ld_last),
      .fin_i     (ld_fin),
      .ready_i   (M_AXIS_TREADY),
      .data_o    (M_AXIS_TDATA),
      .last_o    (M_AXIS_TLAST),
      .fin_o     (fin),
      .valid_o   (M_AXIS_TVALID),
      .can_load_o(can_load)
   );

   assign S_AXIS_TREADY = s_ready;
   assign M_AXIS_TKEEP  = TKEEP_ALL;
   assign frame_done    = M_AXIS_TVALID && M_AXIS_TREADY && fin;
   assign err_tlast     = err_q;

endmodule
